// File: rtl/risc16_pkg.sv
// RISC16 shared definitions: RAM geometry, opcodes,
// data-memory arbiter state and port identifiers.
package risc16_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JAL  = 4'h8;

  typedef enum logic [1:0] {
    ARB_S,
    LOCK_S,
    FORCE_S
  } arb_state_e;

  typedef enum logic {
    PORT_CPU,
    PORT_DBG
  } port_e;

  function automatic port_e other_port(
    input port_e p
  );
    return (p == PORT_CPU) ? PORT_DBG : PORT_CPU;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous RAM, registered read port.
// Contents are not touched by reset; only the read register is.
module data_ram
  import risc16_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// CPU/debug arbiter owning the RISC16 data RAM, with bounded debug lock.
// Define MEM_ARB_RR_EN for round-robin tie-break (else CPU always wins).
module mem_arbiter
  import risc16_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              lock_active
);

  localparam int CNT_W =
    (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(LOCK_MAX - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              lock_active_q;
  logic              resp_valid_q;
  port_e             resp_port_q;
  logic [DATA_W-1:0] cpu_hold_q;
  logic [DATA_W-1:0] dbg_hold_q;

  logic              tie_cpu;
  logic              grant_cpu;
  logic              grant_dbg;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_ARB_RR_EN
  port_e last_grant_q;

  assign tie_cpu =
    (other_port(last_grant_q) == PORT_CPU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_DBG;
    end else if (grant_cpu) begin
      last_grant_q <= PORT_CPU;
    end else if (grant_dbg) begin
      last_grant_q <= PORT_DBG;
    end
  end
`else
  assign tie_cpu = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    cpu_ready  = 1'b0;
    dbg_ready  = 1'b0;
    unique case (state_q)
      ARB_S: begin
        if (cpu_valid && dbg_valid) begin
          cpu_ready = tie_cpu;
          dbg_ready = !tie_cpu;
        end else begin
          cpu_ready = cpu_valid;
          dbg_ready = dbg_valid;
        end
        if (dbg_lock) begin
          state_d    = LOCK_S;
          lock_cnt_d = '0;
        end
      end
      LOCK_S: begin
        dbg_ready  = dbg_valid;
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (!dbg_lock) begin
          state_d = ARB_S;
        end else if (lock_cnt_q == CNT_LAST) begin
          state_d = FORCE_S;
        end
      end
      FORCE_S: begin
        // Slot is spent even with no CPU request.
        cpu_ready = cpu_valid;
        if (dbg_lock) begin
          state_d    = LOCK_S;
          lock_cnt_d = '0;
        end else begin
          state_d = ARB_S;
        end
      end
      default: begin
        state_d = ARB_S;
      end
    endcase
    if (rst) begin
      cpu_ready = 1'b0;
      dbg_ready = 1'b0;
    end
  end

  assign grant_cpu = cpu_valid && cpu_ready;
  assign grant_dbg = dbg_valid && dbg_ready;
  assign ram_en    = grant_cpu || grant_dbg;
  assign ram_we    = grant_cpu ? cpu_we    : dbg_we;
  assign ram_addr  = grant_cpu ? cpu_addr  : dbg_addr;
  assign ram_wdata = grant_cpu ? cpu_wdata : dbg_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_S;
      lock_cnt_q    <= '0;
      lock_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      lock_active_q <= (state_d == LOCK_S);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= PORT_CPU;
    end else begin
      resp_valid_q <= ram_en && !ram_we;
      if (ram_en) begin
        resp_port_q <= grant_dbg ? PORT_DBG : PORT_CPU;
      end
    end
  end

  assign cpu_rvalid =
    resp_valid_q && (resp_port_q == PORT_CPU);
  assign dbg_rvalid =
    resp_valid_q && (resp_port_q == PORT_DBG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      if (cpu_rvalid) begin
        cpu_hold_q <= ram_rdata;
      end
      if (dbg_rvalid) begin
        dbg_hold_q <= ram_rdata;
      end
    end
  end

  assign cpu_rdata   = cpu_rvalid ? ram_rdata : cpu_hold_q;
  assign dbg_rdata   = dbg_rvalid ? ram_rdata : dbg_hold_q;
  assign lock_active = lock_active_q;

  data_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, ties, RAW, lock/force, reset
// during a read. Expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        dbg_valid, dbg_we;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ready, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic        dbg_lock;
  logic        lock_active;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_valid   (cpu_valid),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .dbg_valid   (dbg_valid),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_ready   (dbg_ready),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .dbg_lock    (dbg_lock),
    .lock_active (lock_active)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp_v
  );
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  task automatic drv(
    input logic        cv,
    input logic        cwe,
    input logic [7:0]  ca,
    input logic [15:0] cd,
    input logic        dv,
    input logic        dwe,
    input logic [7:0]  da,
    input logic [15:0] dd,
    input logic        lk
  );
    @(negedge clk);
    cpu_valid = cv;
    cpu_we    = cwe;
    cpu_addr  = ca;
    cpu_wdata = cd;
    dbg_valid = dv;
    dbg_we    = dwe;
    dbg_addr  = da;
    dbg_wdata = dd;
    dbg_lock  = lk;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    bit          lg;
    bit          exp_c;
    logic [15:0] ea;

    rst       = 1'b1;
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 16'h0;
    dbg_valid = 1'b1;
    dbg_we    = 1'b0;
    dbg_addr  = 8'h00;
    dbg_wdata = 16'h0;
    dbg_lock  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_dbg_ready", dbg_ready, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_lock_active", lock_active, 0);
    rst = 1'b0;

    // tie: both write every cycle for 6 cycles
    lg = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 8'(i), 16'(i),
          1, 1, 8'(8'h20 + i), 16'(i), 0);
      exp_c = !RR || lg;
      chk($sformatf("tie_cpu[%0d]", i), cpu_ready, exp_c);
      chk($sformatf("tie_dbg[%0d]", i), dbg_ready, !exp_c);
      lg = !exp_c;
      tick();
    end

    drv(1, 1, 8'h10, 16'hBEEF, 0, 0, 0, 0, 0);
    chk("sw_ready", cpu_ready, 1);
    tick();
    drv(1, 0, 8'h10, 16'h0, 0, 0, 0, 0, 0);
    chk("lw_ready", cpu_ready, 1);
    chk("sw_no_rvalid", cpu_rvalid, 0);
    tick();
    chk("lw_rvalid", cpu_rvalid, 1);
    chk("lw_rdata", cpu_rdata, 16'hBEEF);
    chk("lw_dbg_rvalid", dbg_rvalid, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("hold_rvalid", cpu_rvalid, 0);
    chk("hold_rdata", cpu_rdata, 16'hBEEF);

    ea = 16'h01FF;
    drv(0, 0, 0, 0, 1, 1, ea[7:0], 16'h1234, 0);
    chk("dw_dbg_ready", dbg_ready, 1);
    chk("dw_cpu_ready", cpu_ready, 0);
    tick();
    drv(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0);
    chk("raw_ready", cpu_ready, 1);
    tick();
    chk("raw_rvalid", cpu_rvalid, 1);
    chk("raw_rdata", cpu_rdata, 16'h1234);
    chk("raw_dbg_rdata", dbg_rdata, 0);

    // lock held with CPU waiting: FORCE every 65 cycles
    for (int k = 0; k < 200; k++) begin
      drv(1, 0, 8'h10, 0, 0, 0, 0, 0, 1);
      chk($sformatf("lk_cpu[%0d]", k),
          cpu_ready, (k % 65) == 0);
      chk($sformatf("lk_act[%0d]", k),
          lock_active, (k % 65) != 0);
      chk($sformatf("lk_dbg[%0d]", k), dbg_ready, 0);
      tick();
    end

    drv(1, 1, 8'h30, 16'h0, 1, 1, 8'h31, 16'h0, 0);
    chk("drop_dbg", dbg_ready, 1);
    chk("drop_cpu", cpu_ready, 0);
    chk("drop_act", lock_active, 1);
    tick();
    lg = 1'b1;
    drv(1, 1, 8'h30, 16'h0, 1, 1, 8'h31, 16'h0, 0);
    exp_c = !RR || lg;
    chk("arb1_cpu", cpu_ready, exp_c);
    chk("arb1_dbg", dbg_ready, !exp_c);
    chk("arb1_act", lock_active, 0);
    lg = !exp_c;
    tick();
    drv(1, 1, 8'h30, 16'h0, 1, 1, 8'h31, 16'h0, 0);
    exp_c = !RR || lg;
    chk("arb2_cpu", cpu_ready, exp_c);
    chk("arb2_dbg", dbg_ready, !exp_c);
    tick();

    drv(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    chk("mr_ready", cpu_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_rvalid", cpu_rvalid, 0);
    chk("mr_rdata", cpu_rdata, 0);
    chk("mr_cpu_ready", cpu_ready, 0);
    chk("mr_dbg_ready", dbg_ready, 0);
    chk("mr_dbg_rdata", dbg_rdata, 0);
    chk("mr_act", lock_active, 0);
    tick();
    chk("mr_rvalid2", cpu_rvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    drv(1, 0, 8'h10, 0, 1, 1, 8'h40, 16'h5, 0);
    chk("post_cpu", cpu_ready, 1);
    chk("post_dbg", dbg_ready, 0);
    chk("post_act", lock_active, 0);
    tick();
    chk("post_rvalid", cpu_rvalid, 1);
    chk("post_rdata", cpu_rdata, 16'hBEEF);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
